fb_draw_arbiter: RTL and testbench
==================================

# fb_draw_arbiter

CHIP-8 framebuffer controller. Executes sprite draws (DRW: read-modify-write XOR with collision detect) and screen clears (CLS) against the single-port 256-byte display RAM, and shares that port with the VGA scan-out path. Sits between the CPU core and the display RAM; the display reads through it with priority.

## Interface
Parameters:
- FB_BYTES, 256, framebuffer size in bytes (32 rows x 8 bytes; fixed)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- draw_start  in  1  1-cycle request to draw a sprite
- draw_x  in  6  sprite X (pixel column 0..63)
- draw_y  in  5  sprite Y (pixel row 0..31)
- draw_n  in  4  sprite height in bytes (0..15)
- clear_start  in  1  1-cycle request to clear the screen
- spr_idx  out  4  sprite byte index currently needed (0..n-1)
- spr_data  in  8  sprite byte at I+spr_idx, combinational, valid in the same cycle
- busy  out  1  operation in progress
- done  out  1  1-cycle pulse on completion
- collision  out  1  draw turned ≥1 lit pixel off; valid from done until next accepted start
- disp_req  in  1  display read request (has priority)
- disp_addr  in  8  display read address
- disp_valid  out  1  disp_data valid (1 cycle after granted disp_req)
- disp_data  out  8  display read data
- fb_addr  out  8  RAM address
- fb_we  out  1  RAM write enable
- fb_wdata  out  8  RAM write data
- fb_rdata  in  8  RAM read data, 1-cycle synchronous latency

## Operation
- Address map: addr = row*8 + col[5:3]; bit 7 of a byte is the leftmost pixel.
- States: IDLE, CLR, RD_L, CAP_L, WR_L, RD_R, CAP_R, WR_R, DONE.
- IDLE: clear_start → CLR (addr counter 0, collision←0). Else draw_start → RD_L (row r=0, collision←0), or → DONE if draw_n=0. Both asserted: clear wins, draw dropped. Starts outside IDLE are ignored.
- CLR: write 0x00 at counter; counter+1; after address 255 → DONE.
- Per sprite row r: sh=x[2:0], yr=(y+r) mod 32, L=yr*8+x[5:3], R=yr*8+((x[5:3]+1) mod 8) (wraps within the row). spr_idx=r.
  - RD_L: issue read of L → CAP_L.
  - CAP_L: rbuf←fb_rdata (port free) → WR_L.
  - WR_L: m=spr_data>>sh; write rbuf^m at L; collision|=|(rbuf&m). → RD_R if sh≠0. Else → next row.
  - RD_R/CAP_R/WR_R: same flow at R, with m=(spr_data<<(8-sh))[7:0].
  - Next row: r+1; after r=n-1 → DONE.
- Y wraps mod 32 and X wraps mod 64. Sprites are never clipped.
- DONE: done=1 for one cycle, then → IDLE.
- Arbitration: when disp_req=1, fb_addr=disp_addr and fb_we=0. The next cycle gives disp_valid=1 and disp_data=fb_rdata. Any port-using state (CLR, RD_*, WR_*) holds in place, with no side effects, while disp_req=1. CAP_* never needs the port, so a display read in a CAP cycle does not stall. Read data always belongs to the issuer of the previous cycle.
- Port outputs are combinational from state and disp_req. fb_we=0 in IDLE, CAP_*, DONE.

## Timing
- Reset values:
  - State IDLE.
  - busy, done, collision, disp_valid = 0.
  - disp_data, spr_idx = 0.
  - fb_we = 0.
  - fb_addr = disp_addr if disp_req, else 0.
- busy is 1 from the cycle after an accepted start through DONE inclusive.
- Latency with no stalls, start at cycle 0:
  - Aligned draw: done at 1+3n.
  - Unaligned draw: done at 1+6n.
  - n=0: done at 1.
  - Clear: done at 257.
- Each stall cycle adds exactly 1 cycle.
- Reset asserted mid-operation aborts it in the same edge with no further writes. RAM contents are left partial.

## Test plan
- Clear: RAM prefilled 0xA5, clear_start at c0 → fb_we with data 0x00 at addrs 0..255 over c1..c256, done at c257, all bytes 0, collision=0.
- Aligned draw: x=8, y=2, n=1, spr 0xF0 on empty fb → addr 17=0xF0, done at c4, collision=0. Repeat the draw → addr 17=0x00, collision=1.
- Unaligned draw: x=3, y=0, n=1, spr 0xFF on empty fb → addr0=0x1F, addr1=0xE0, done at c7, collision=0.
- Wrap: x=62, y=31, n=2, spr {0xFF, 0x81} on empty fb → addr255=0x03, addr248=0xFC, addr7=0x02, addr0=0x04. Done at c13.
- Contention: disp_req held 5 cycles during the test-3 draw, reading addr 0 → disp_valid each following cycle with current addr0 data. Final RAM identical to test 3, done delayed exactly 5 cycles.
- Control edge cases:
  - clear_start+draw_start same cycle → clear only.
  - draw_start while busy → ignored.
  - reset at CLR counter 100 → busy=0 next cycle, addrs ≥100 untouched.

Source files
------------

// File: rtl/fb_draw_arbiter.sv
// Framebuffer controller: sprite XOR draws and screen clears on a single-port
// display RAM, with the display scan-out path taking priority on the port.
module fb_draw_arbiter #(
    parameter int FB_BYTES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw_start,
    input  logic [5:0] draw_x,
    input  logic [4:0] draw_y,
    input  logic [3:0] draw_n,
    input  logic       clear_start,
    output logic [3:0] spr_idx,
    input  logic [7:0] spr_data,
    output logic       busy,
    output logic       done,
    output logic       collision,
    input  logic       disp_req,
    input  logic [7:0] disp_addr,
    output logic       disp_valid,
    output logic [7:0] disp_data,
    output logic [7:0] fb_addr,
    output logic       fb_we,
    output logic [7:0] fb_wdata,
    input  logic [7:0] fb_rdata
);
    localparam logic [7:0] LAST_ADDR = 8'(FB_BYTES - 1);

    // state | meaning
    // IDLE  | waiting for start       CLR   | zero one byte per cycle
    // RD_*  | read left/right byte    CAP_* | capture read data
    // WR_*  | write XORed byte        DONE  | one-cycle completion pulse
    typedef enum logic [3:0] {
        IDLE, CLR, RD_L, CAP_L, WR_L, RD_R, CAP_R, WR_R, DONE
    } state_t;

    state_t     state, state_next;
    logic [7:0] clr_cnt;
    logic [5:0] x_q;
    logic [4:0] y_q;
    logic [3:0] n_q;
    logic [3:0] row;
    logic [7:0] rbuf;
    logic       coll_q;
    logic       disp_valid_q;

    logic [2:0] sh;
    logic [4:0] yr;
    logic [7:0] addr_l, addr_r;
    logic [7:0] mask_l, mask_r;
    logic       last_row;
    logic       port_state;
    logic       advance;

    assign sh       = x_q[2:0];
    assign yr       = y_q + {1'b0, row};
    assign addr_l   = {yr, x_q[5:3]};
    assign addr_r   = {yr, x_q[5:3] + 3'd1};
    assign mask_l   = spr_data >> sh;
    assign mask_r   = spr_data << (4'd8 - {1'b0, sh});
    assign last_row = (row == n_q - 4'd1);

    assign port_state = (state == CLR) || (state == RD_L) || (state == WR_L) ||
                        (state == RD_R) || (state == WR_R);
    // The display owns the port this cycle; port users freeze with no side effects.
    assign advance = !(disp_req && port_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fb_addr    = 8'h00;
        fb_we      = 1'b0;
        fb_wdata   = 8'h00;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next = CLR;
                end else if (draw_start) begin
                    state_next = (draw_n == 4'd0) ? DONE : RD_L;
                end
            end
            CLR: begin
                fb_addr = clr_cnt;
                fb_we   = 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next = DONE;
                end
            end
            RD_L: begin
                fb_addr    = addr_l;
                state_next = CAP_L;
            end
            CAP_L: state_next = WR_L;
            WR_L: begin
                fb_addr  = addr_l;
                fb_we    = 1'b1;
                fb_wdata = rbuf ^ mask_l;
                if (sh != 3'd0) begin
                    state_next = RD_R;
                end else begin
                    state_next = last_row ? DONE : RD_L;
                end
            end
            RD_R: begin
                fb_addr    = addr_r;
                state_next = CAP_R;
            end
            CAP_R: state_next = WR_R;
            WR_R: begin
                fb_addr    = addr_r;
                fb_we      = 1'b1;
                fb_wdata   = rbuf ^ mask_r;
                state_next = last_row ? DONE : RD_L;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (disp_req) begin
            fb_addr  = disp_addr;
            fb_we    = 1'b0;
            fb_wdata = 8'h00;
            if (port_state) begin
                state_next = state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt      <= 8'h00;
            x_q          <= 6'd0;
            y_q          <= 5'd0;
            n_q          <= 4'd0;
            row          <= 4'd0;
            rbuf         <= 8'h00;
            coll_q       <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            disp_valid_q <= disp_req;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        clr_cnt <= 8'h00;
                        coll_q  <= 1'b0;
                    end else if (draw_start) begin
                        x_q    <= draw_x;
                        y_q    <= draw_y;
                        n_q    <= draw_n;
                        row    <= 4'd0;
                        coll_q <= 1'b0;
                    end
                end
                CLR: begin
                    if (advance) begin
                        clr_cnt <= clr_cnt + 8'd1;
                    end
                end
                CAP_L, CAP_R: rbuf <= fb_rdata;
                WR_L: begin
                    if (advance) begin
                        coll_q <= coll_q | (|(rbuf & mask_l));
                        if (sh == 3'd0 && !last_row) begin
                            row <= row + 4'd1;
                        end
                    end
                end
                WR_R: begin
                    if (advance) begin
                        coll_q <= coll_q | (|(rbuf & mask_r));
                        if (!last_row) begin
                            row <= row + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign collision  = coll_q;
    assign spr_idx    = row;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_valid_q ? fb_rdata : 8'h00;

endmodule

// File: tb/tb_fb_draw_arbiter.sv
// Bench for fb_draw_arbiter: pixel-level framebuffer model, done/display scoreboards.
module tb_fb_draw_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       draw_start = 1'b0;
    logic [5:0] draw_x = 6'd0;
    logic [4:0] draw_y = 5'd0;
    logic [3:0] draw_n = 4'd0;
    logic       clear_start = 1'b0;
    logic [3:0] spr_idx;
    logic [7:0] spr_data;
    logic       busy, done, collision;
    logic       disp_req = 1'b0;
    logic [7:0] disp_addr = 8'h00;
    logic       disp_valid;
    logic [7:0] disp_data;
    logic [7:0] fb_addr;
    logic       fb_we;
    logic [7:0] fb_wdata;
    logic [7:0] fb_rdata;

    fb_draw_arbiter #(.FB_BYTES(256)) dut (
        .clk(clk), .reset(reset),
        .draw_start(draw_start), .draw_x(draw_x), .draw_y(draw_y), .draw_n(draw_n),
        .clear_start(clear_start), .spr_idx(spr_idx), .spr_data(spr_data),
        .busy(busy), .done(done), .collision(collision),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Display RAM: one port, synchronous read.
    logic [7:0] ram [0:255];
    logic       fill_en = 1'b0;
    logic [7:0] fill_val = 8'h00;
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) ram[i] <= fill_val;
        end else if (fb_we) begin
            ram[fb_addr] <= fb_wdata;
        end
        fb_rdata <= ram[fb_addr];
    end

    logic [7:0] spr_mem [0:15];
    assign spr_data = spr_mem[spr_idx];

    // Reference model: 64x32 pixel screen.
    bit pix [0:31][0:63];

    typedef struct { int cyc; logic coll; } done_exp_t;
    done_exp_t  exp_done[$];
    logic [7:0] exp_disp[$];

    bit clr_mode = 1'b0;
    int clr_idx = 0;
    int clr_bad = 0;

    function automatic logic [7:0] model_byte(input int a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = pix[a / 8][(a % 8) * 8 + 7 - i];
        return b;
    endfunction

    function automatic void model_set_byte(input int a, input logic [7:0] v);
        for (int i = 0; i < 8; i++) pix[a / 8][(a % 8) * 8 + 7 - i] = v[i];
    endfunction

    function automatic logic model_draw(input int x, input int y, input int n);
        logic c = 1'b0;
        logic [7:0] s;
        for (int r = 0; r < n; r++) begin
            s = spr_mem[r];
            for (int b = 0; b < 8; b++) begin
                if (s[7 - b]) begin
                    if (pix[(y + r) % 32][(x + b) % 64]) c = 1'b1;
                    pix[(y + r) % 32][(x + b) % 64] = ~pix[(y + r) % 32][(x + b) % 64];
                end
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin : monitor
        done_exp_t e;
        logic [7:0] d;
        if (!reset) begin
            if (done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    e = exp_done.pop_front();
                    if (cyc != e.cyc) begin
                        failures++;
                        $display("FAIL done_cycle actual=%0d required=%0d", cyc, e.cyc);
                    end
                    checks++;
                    if (collision !== e.coll) begin
                        failures++;
                        $display("FAIL collision actual=%b required=%b", collision, e.coll);
                    end
                end
            end
            if (disp_valid) begin
                checks++;
                if (exp_disp.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_disp_valid at cycle %0d", cyc);
                end else begin
                    d = exp_disp.pop_front();
                    if (disp_data !== d) begin
                        failures++;
                        $display("FAIL disp_data actual=%h required=%h", disp_data, d);
                    end
                end
            end
            if (clr_mode && fb_we) begin
                if (fb_addr != clr_idx[7:0] || fb_wdata != 8'h00) clr_bad++;
                clr_idx++;
            end
        end
    end

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_ram(input string name);
        int bad = 0;
        int first = -1;
        for (int a = 0; a < 256; a++) begin
            if (ram[a] !== model_byte(a)) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ram_%s bad_bytes=%0d first_addr=%0d actual=%h required=%h",
                     name, bad, first, ram[first], model_byte(first));
        end
    endtask

    task automatic wait_done();
        int budget = 2000;
        while (exp_done.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (exp_done.size() != 0) begin
            failures++;
            $display("FAIL done_timeout pending=%0d required=0", exp_done.size());
            exp_done.delete();
        end
    endtask

    task automatic fill(input logic [7:0] v);
        @(posedge clk); #1;
        fill_en = 1'b1;
        fill_val = v;
        @(posedge clk); #1;
        fill_en = 1'b0;
        for (int a = 0; a < 256; a++) model_set_byte(a, v);
    endtask

    task automatic issue_clear(input bit with_draw, input bit log_writes);
        done_exp_t e;
        @(posedge clk); #1;
        clear_start = 1'b1;
        if (with_draw) begin
            draw_start = 1'b1;
            draw_x = 6'd9;
            draw_y = 5'd4;
            draw_n = 4'd3;
        end
        e.cyc = cyc + 257;
        e.coll = 1'b0;
        exp_done.push_back(e);
        for (int a = 0; a < 256; a++) model_set_byte(a, 8'h00);
        if (log_writes) begin
            clr_idx = 0;
            clr_bad = 0;
            clr_mode = 1'b1;
        end
        @(posedge clk); #1;
        clear_start = 1'b0;
        draw_start = 1'b0;
        check_val("busy_after_clear_start", int'(busy), 1);
        wait_done();
        clr_mode = 1'b0;
        if (log_writes) begin
            check_val("clear_write_count", clr_idx, 256);
            check_val("clear_write_bad", clr_bad, 0);
        end
        check_ram("clear");
    endtask

    // d_off/d_len: display read window in cycles after start; extra: expected stall cycles.
    task automatic issue_draw(input int x, input int y, input int n, input int d_off,
                              input int d_len, input int extra, input bit junk,
                              input int daddr);
        done_exp_t e;
        logic [7:0] snap;
        int last_j;
        int s;
        @(posedge clk); #1;
        draw_x = x[5:0];
        draw_y = y[4:0];
        draw_n = n[3:0];
        draw_start = 1'b1;
        s = cyc;
        snap = model_byte(daddr);
        e.coll = model_draw(x, y, n);
        e.cyc = s + 1 + ((n == 0) ? 0 : ((x % 8 == 0) ? 3 * n : 6 * n)) + extra;
        exp_done.push_back(e);
        @(posedge clk); #1;
        draw_start = 1'b0;
        check_val("busy_after_draw_start", int'(busy), 1);
        last_j = (d_len > 0) ? d_off + d_len - 1 : 0;
        if (junk && last_j < 2) last_j = 2;
        for (int j = 1; j <= last_j; j++) begin
            disp_req = (d_len > 0 && j >= d_off && j < d_off + d_len);
            disp_addr = daddr[7:0];
            if (disp_req) exp_disp.push_back(snap);
            draw_start = junk && (j == 2);
            clear_start = junk && (j == 2);
            if (junk && j == 2) begin
                draw_x = 6'($urandom);
                draw_y = 5'($urandom);
                draw_n = 4'd1;
            end
            @(posedge clk); #1;
        end
        disp_req = 1'b0;
        draw_start = 1'b0;
        clear_start = 1'b0;
        wait_done();
        check_ram("draw");
    endtask

    task automatic disp_read(input int a);
        @(posedge clk); #1;
        disp_req = 1'b1;
        disp_addr = a[7:0];
        exp_disp.push_back(model_byte(a));
        @(posedge clk); #1;
        disp_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int x, y, n, st, budget;
        for (int k = 0; k < 16; k++) spr_mem[k] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_done", int'(done), 0);
        check_val("reset_collision", int'(collision), 0);
        check_val("reset_disp_valid", int'(disp_valid), 0);
        check_val("reset_disp_data", int'(disp_data), 0);
        check_val("reset_spr_idx", int'(spr_idx), 0);
        check_val("reset_fb_we", int'(fb_we), 0);
        check_val("reset_fb_addr", int'(fb_addr), 0);
        reset = 1'b0;

        // Clear over a prefilled RAM
        fill(8'hA5);
        issue_clear(1'b0, 1'b1);

        // Aligned draw then the same draw again (erases, collides)
        spr_mem[0] = 8'hF0;
        issue_draw(8, 2, 1, 0, 0, 0, 1'b0, 0);
        check_val("aligned_addr17", int'(ram[17]), 8'hF0);
        issue_draw(8, 2, 1, 0, 0, 0, 1'b0, 0);
        check_val("aligned_redraw_addr17", int'(ram[17]), 8'h00);

        // Unaligned draw
        spr_mem[0] = 8'hFF;
        issue_draw(3, 0, 1, 0, 0, 0, 1'b0, 0);
        check_val("unaligned_addr0", int'(ram[0]), 8'h1F);
        check_val("unaligned_addr1", int'(ram[1]), 8'hE0);

        // X and Y wrap
        issue_clear(1'b0, 1'b0);
        spr_mem[0] = 8'hFF;
        spr_mem[1] = 8'h81;
        issue_draw(62, 31, 2, 0, 0, 0, 1'b0, 0);
        check_val("wrap_addr255", int'(ram[255]), 8'h03);
        check_val("wrap_addr248", int'(ram[248]), 8'hFC);
        check_val("wrap_addr7", int'(ram[7]), 8'h02);
        check_val("wrap_addr0", int'(ram[0]), 8'h04);

        // Contention: five display reads while the draw waits in its first read
        issue_clear(1'b0, 1'b0);
        spr_mem[0] = 8'hFF;
        issue_draw(3, 0, 1, 1, 5, 5, 1'b0, 0);
        check_val("contend_addr0", int'(ram[0]), 8'h1F);
        check_val("contend_addr1", int'(ram[1]), 8'hE0);

        // A display read landing on the capture cycle costs nothing
        spr_mem[0] = 8'h3C;
        issue_draw(24, 9, 1, 2, 1, 0, 1'b0, 75);

        // Starts while busy are ignored
        for (int k = 0; k < 16; k++) spr_mem[k] = 8'($urandom);
        issue_draw(16, 5, 3, 0, 0, 0, 1'b1, 0);

        // Clear and draw together: clear only
        issue_clear(1'b1, 1'b0);

        // n = 0 finishes immediately
        issue_draw(5, 5, 0, 0, 0, 0, 1'b0, 0);

        // Randomised draws with optional display stalls
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < 16; k++) spr_mem[k] = 8'($urandom);
            x = $urandom_range(0, 63);
            if (it % 3 == 0) x = x & ~7;
            y = $urandom_range(0, 31);
            n = $urandom_range(0, 15);
            st = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
            issue_draw(x, y, n, 1, st, st, 1'b0, $urandom_range(0, 255));
            if (it % 6 == 5) disp_read($urandom_range(0, 255));
        end

        // Reset in the middle of a clear
        fill(8'hA5);
        @(posedge clk); #1;
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        budget = 400;
        while (!(fb_we && fb_addr == 8'd99) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val("reset_mid_clear_reached", int'(budget > 0), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("reset_mid_busy", int'(busy), 0);
        check_val("reset_mid_fb_we", int'(fb_we), 0);
        reset = 1'b0;
        for (int a = 0; a < 256; a++) model_set_byte(a, (a < 100) ? 8'h00 : 8'hA5);
        repeat (3) @(posedge clk);
        #1;
        check_ram("reset_mid_clear");

        disp_read(150);
        disp_read(42);
        repeat (4) @(posedge clk);
        #1;
        check_val("disp_queue_drained", exp_disp.size(), 0);
        check_val("done_queue_drained", exp_done.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
